// File: rtl/instr_issue_pkg.sv
// instr_issue_pkg: shared field constants, multiDiv codes, FSM states and mul/div decode helper
package instr_issue_pkg;

    localparam logic [3:0] OP_TYPE_A = 4'b1111;
    localparam logic [3:0] FUNCT_MUL = 4'b0100;
    localparam logic [3:0] FUNCT_DIV = 4'b0101;

    localparam logic [1:0] MD_NONE = 2'b00;
    localparam logic [1:0] MD_MUL  = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    function automatic logic [1:0] md_decode(input logic [3:0] opc, input logic [3:0] fn);
        return (opc != OP_TYPE_A) ? MD_NONE :
               (fn == FUNCT_MUL)  ? MD_MUL  :
               (fn == FUNCT_DIV)  ? MD_DIV  : MD_NONE;
    endfunction

endpackage

// File: rtl/issue_muldiv_timer.sv
// issue_muldiv_timer: down-counter that tracks the remaining held cycles of a mul/div
//  clk, rst     : clock, synchronous active-high reset
//  i_clr        : flush, clears the count
//  i_load       : load i_load_val (N-1) on the issue edge
//  o_zero       : count is zero (last held cycle or idle)
//  o_last       : count is one (the next cycle is the last held one)
module issue_muldiv_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero,
    output logic         o_last
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);
    assign o_last = (r_cnt == W'(1));

endmodule

// File: rtl/instr_issue.sv
// instr_issue: accepts fetch words, splits fields, decodes multiDiv and holds mul/div for its latency
//  clk, rst            : clock, synchronous active-high reset
//  in_valid/in_instr   : fetch handshake input, in_ready back to fetch
//  flush               : drop any held instruction, outputs go NOP next cycle
//  opcode/op1/op2/funct: registered instruction fields
//  multiDiv            : 00 none, 01 mul, 10 div
//  issue_valid         : outputs carry a real instruction
//  muldiv_last         : final held cycle of a mul/div
//  ISSUE_PERF_EN       : when defined adds issued_cnt and stall_cnt counters
module instr_issue
    import instr_issue_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned DIV_CYCLES = 8,
    parameter logic [3:0]  NOP_OPCODE = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    input  logic        flush,
    output logic [3:0]  opcode,
    output logic [1:0]  multiDiv,
    output logic [3:0]  op1,
    output logic [3:0]  op2,
    output logic [3:0]  funct,
    output logic        issue_valid,
    output logic        muldiv_last
`ifdef ISSUE_PERF_EN
    ,
    output logic [31:0] issued_cnt,
    output logic [31:0] stall_cnt
`endif
);

    localparam int unsigned MAX_N = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAX_N) + 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic [1:0]       w_md;
    logic             w_is_md;
    logic             w_multi;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_cnt_zero;
    logic             w_cnt_last;
    logic             w_hold;

    assign w_accept   = in_valid && in_ready;
    assign w_md       = md_decode(in_instr[15:12], in_instr[3:0]);
    assign w_is_md    = (w_md != MD_NONE);
    // Only latencies above one need the WAIT state; N==1 issues like a plain op
    assign w_multi    = ((w_md == MD_MUL) && (MUL_CYCLES > 1)) || ((w_md == MD_DIV) && (DIV_CYCLES > 1));
    assign w_load     = w_accept && w_multi;
    assign w_load_val = (w_md == MD_MUL) ? MUL_LOAD : DIV_LOAD;
    assign w_hold     = (r_state == S_WAIT) && !w_cnt_zero;

    issue_muldiv_timer #(.W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (flush),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_cnt_zero),
        .o_last     (w_cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_RUN;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        if (!rst && !flush)
            in_ready = (r_state == S_RUN) || w_cnt_zero;
        if (flush)
            w_state_nxt = S_RUN;
        else if (w_accept)
            w_state_nxt = w_load ? S_WAIT : S_RUN;
        else if ((r_state == S_WAIT) && w_cnt_zero)
            w_state_nxt = S_RUN;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            opcode      <= NOP_OPCODE;
            multiDiv    <= MD_NONE;
            op1         <= '0;
            op2         <= '0;
            funct       <= '0;
            issue_valid <= 1'b0;
            muldiv_last <= 1'b0;
        end else if (w_accept) begin
            opcode      <= in_instr[15:12];
            op1         <= in_instr[11:8];
            op2         <= in_instr[7:4];
            funct       <= in_instr[3:0];
            multiDiv    <= w_md;
            issue_valid <= 1'b1;
            // A single-cycle mul/div is its own last cycle
            muldiv_last <= w_is_md && !w_multi;
        end else if (w_hold) begin
            muldiv_last <= w_cnt_last;
        end else begin
            opcode      <= NOP_OPCODE;
            multiDiv    <= MD_NONE;
            op1         <= '0;
            op2         <= '0;
            funct       <= '0;
            issue_valid <= 1'b0;
            muldiv_last <= 1'b0;
        end
    end

`ifdef ISSUE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (w_accept)
                issued_cnt <= issued_cnt + 32'd1;
            if (in_valid && !in_ready && !flush)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_issue.sv
// tb_instr_issue: directed and randomized checks of instr_issue against a cycle-number reference model
module tb_instr_issue;

    localparam int MUL_N = 3;
    localparam int DIV_N = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] in_instr = 16'h0000;
    logic        in_ready;
    logic [3:0]  opcode, op1, op2, funct;
    logic [1:0]  multiDiv;
    logic        issue_valid, muldiv_last;
`ifdef ISSUE_PERF_EN
    logic [31:0] issued_cnt, stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_issue dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .flush       (flush),
        .opcode      (opcode),
        .multiDiv    (multiDiv),
        .op1         (op1),
        .op2         (op2),
        .funct       (funct),
        .issue_valid (issue_valid),
        .muldiv_last (muldiv_last)
`ifdef ISSUE_PERF_EN
        ,
        .issued_cnt  (issued_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    wire [19:0] w_out = {opcode, op1, op2, funct, multiDiv, issue_valid, muldiv_last};
    wire [7:0]  w_nop = {opcode, multiDiv, issue_valid, muldiv_last};

    function automatic logic [1:0] md_of(input logic [15:0] ins);
        if (ins[15:12] != 4'hF) return 2'b00;
        if (ins[3:0] == 4'h4) return 2'b01;
        if (ins[3:0] == 4'h5) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int n_of(input logic [15:0] ins);
        return (md_of(ins) == 2'b01) ? MUL_N : (md_of(ins) == 2'b10) ? DIV_N : 1;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; in_instr = 16'h1234; flush = 1'b0;
        step; step;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", in_ready); end
        n_cmp++; if (w_nop !== 8'h00) begin n_err++; $display("FAIL reset_out: got %h want 00", w_nop); end
        n_cmp++; if ({op1, op2, funct} !== 12'h000) begin n_err++; $display("FAIL reset_fields: got %h want 000", {op1, op2, funct}); end
        rst = 1'b0; in_valid = 1'b0; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_plain;
        in_instr = 16'h1234; in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        n_cmp++; if (w_out !== {16'h1234, 4'b0010}) begin n_err++; $display("FAIL plain_out: got %h want %h", w_out, {16'h1234, 4'b0010}); end
        step;
        n_cmp++; if (w_nop !== 8'h00) begin n_err++; $display("FAIL plain_nop: got %h want 00", w_nop); end
    endtask

    task automatic test_mul;
        rst = 1'b1; in_valid = 1'b0;
        step;
        rst = 1'b0; in_valid = 1'b1; in_instr = 16'hF124;
        step;
        in_instr = 16'h2000; #1;
        n_cmp++; if (w_out !== {16'hF124, 4'b0110}) begin n_err++; $display("FAIL mul_c1_out: got %h want %h", w_out, {16'hF124, 4'b0110}); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mul_c1_ready: got %b want 0", in_ready); end
        step;
        n_cmp++; if (w_out !== {16'hF124, 4'b0110}) begin n_err++; $display("FAIL mul_c2_out: got %h want %h", w_out, {16'hF124, 4'b0110}); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mul_c2_ready: got %b want 0", in_ready); end
        step;
        n_cmp++; if (w_out !== {16'hF124, 4'b0111}) begin n_err++; $display("FAIL mul_c3_out: got %h want %h", w_out, {16'hF124, 4'b0111}); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mul_c3_ready: got %b want 1", in_ready); end
        step;
        in_valid = 1'b0;
        n_cmp++; if (w_out !== {16'h2000, 4'b0010}) begin n_err++; $display("FAIL mul_c4_out: got %h want %h", w_out, {16'h2000, 4'b0010}); end
`ifdef ISSUE_PERF_EN
        n_cmp++; if (issued_cnt !== 32'd2) begin n_err++; $display("FAIL mul_issued_cnt: got %0d want 2", issued_cnt); end
        n_cmp++; if (stall_cnt !== 32'd2) begin n_err++; $display("FAIL mul_stall_cnt: got %0d want 2", stall_cnt); end
`endif
    endtask

    task automatic test_div_flush;
        in_instr = 16'hF125; in_valid = 1'b1;
        step;
        in_valid = 1'b0; #1;
        n_cmp++; if (w_out !== {16'hF125, 4'b1010}) begin n_err++; $display("FAIL div_c1_out: got %h want %h", w_out, {16'hF125, 4'b1010}); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL div_c1_ready: got %b want 0", in_ready); end
        step;
        n_cmp++; if (w_out !== {16'hF125, 4'b1010}) begin n_err++; $display("FAIL div_c2_out: got %h want %h", w_out, {16'hF125, 4'b1010}); end
        step;
        flush = 1'b1; in_valid = 1'b1; in_instr = 16'h3000; #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL div_flush_ready: got %b want 0", in_ready); end
        step;
        flush = 1'b0; in_valid = 1'b0; #1;
        n_cmp++; if (w_nop !== 8'h00) begin n_err++; $display("FAIL div_flush_nop: got %h want 00", w_nop); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL div_flush_ready_after: got %b want 1", in_ready); end
    endtask

    task automatic test_bubble;
        in_instr = 16'hA000; in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        n_cmp++; if (w_out !== {16'hA000, 4'b0010}) begin n_err++; $display("FAIL bubble_a: got %h want %h", w_out, {16'hA000, 4'b0010}); end
        step;
        in_instr = 16'hB000; in_valid = 1'b1;
        n_cmp++; if (w_nop !== 8'h00) begin n_err++; $display("FAIL bubble_nop: got %h want 00", w_nop); end
        step;
        in_valid = 1'b0;
        n_cmp++; if (w_out !== {16'hB000, 4'b0010}) begin n_err++; $display("FAIL bubble_b: got %h want %h", w_out, {16'hB000, 4'b0010}); end
    endtask

    task automatic test_reset_mid_wait;
        in_instr = 16'hF125; in_valid = 1'b1;
        step;
        in_valid = 1'b0; rst = 1'b1; #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rstwait_ready: got %b want 0", in_ready); end
        step;
        rst = 1'b0; #1;
        n_cmp++; if (w_nop !== 8'h00) begin n_err++; $display("FAIL rstwait_nop: got %h want 00", w_nop); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstwait_ready_after: got %b want 1", in_ready); end
        step;
        n_cmp++; if (w_nop !== 8'h00) begin n_err++; $display("FAIL rstwait_no_hold: got %h want 00", w_nop); end
    endtask

    // Reference: an instruction accepted at edge k is visible in cycles k..k+N-1; ready returns on cycle k+N-1
    task automatic test_random;
        logic [15:0] m_instr = 16'h0000;
        logic [15:0] ins;
        logic [19:0] exp_out;
        bit m_live = 0;
        bit v, f, r;
        int m_end = -1;
        int cyc = 0;
        int m_iss = 0;
        int m_stall = 0;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
        step;
        rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (m_live && cyc <= m_end) begin
                exp_out = {m_instr, md_of(m_instr), 1'b1, (md_of(m_instr) != 2'b00) && (cyc == m_end)};
                n_cmp++; if (w_out !== exp_out) begin n_err++; $display("FAIL rand_out cyc %0d: got %h want %h", cyc, w_out, exp_out); end
            end else begin
                n_cmp++; if (w_nop !== 8'h00) begin n_err++; $display("FAIL rand_nop cyc %0d: got %h want 00", cyc, w_nop); end
            end
            v = ($urandom % 4) != 0;
            f = ($urandom % 16) == 0;
            ins = 16'($urandom);
            if (($urandom % 2) == 0) begin
                ins[15:12] = 4'hF;
                ins[3:0] = (($urandom % 2) == 0) ? 4'h4 : 4'h5;
            end
            in_valid = v; flush = f; in_instr = ins; #1;
            r = !f && (!m_live || cyc >= m_end);
            n_cmp++; if (in_ready !== r) begin n_err++; $display("FAIL rand_ready cyc %0d: got %b want %b", cyc, in_ready, r); end
            if (v && !r && !f) m_stall++;
            step;
            cyc++;
            if (f) m_live = 0;
            else if (v && r) begin
                m_live = 1;
                m_instr = ins;
                m_end = cyc + n_of(ins) - 1;
                m_iss++;
            end
        end
        in_valid = 1'b0; flush = 1'b0;
`ifdef ISSUE_PERF_EN
        n_cmp++; if (issued_cnt !== 32'(m_iss)) begin n_err++; $display("FAIL rand_issued_cnt: got %0d want %0d", issued_cnt, m_iss); end
        n_cmp++; if (stall_cnt !== 32'(m_stall)) begin n_err++; $display("FAIL rand_stall_cnt: got %0d want %0d", stall_cnt, m_stall); end
`endif
    endtask

    initial begin
        test_reset;
        test_plain;
        test_mul;
        test_div_flush;
        test_bubble;
        test_reset_mid_wait;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
